// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if: cache/memory bus bundle; slave = arbiter view, master = caches and memory view
interface cache_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
);
  logic                  icache_pmem_read;
  logic [ADDR_WIDTH-1:0] icache_pmem_address;
  logic [LINE_WIDTH-1:0] icache_pmem_rdata;
  logic                  icache_pmem_resp;
  logic                  dcache_pmem_read;
  logic                  dcache_pmem_write;
  logic [ADDR_WIDTH-1:0] dcache_pmem_address;
  logic [LINE_WIDTH-1:0] dcache_pmem_wdata;
  logic [LINE_WIDTH-1:0] dcache_pmem_rdata;
  logic                  dcache_pmem_resp;
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;
  modport slave (
    input  icache_pmem_read, icache_pmem_address, dcache_pmem_read, dcache_pmem_write,
           dcache_pmem_address, dcache_pmem_wdata, pmem_rdata, pmem_resp,
    output icache_pmem_rdata, icache_pmem_resp, dcache_pmem_rdata, dcache_pmem_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );
  modport master (
    output icache_pmem_read, icache_pmem_address, dcache_pmem_read, dcache_pmem_write,
           dcache_pmem_address, dcache_pmem_wdata, pmem_rdata, pmem_resp,
    input  icache_pmem_rdata, icache_pmem_resp, dcache_pmem_rdata, dcache_pmem_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin I/D cache arbiter onto one pmem port; ports clk, reset (sync, active-high), bus (cache_arbiter_if.slave)
module cache_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input logic           clk,
  input logic           reset,
  cache_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
  state_t                r_state, w_next;
  logic                  r_last_grant;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic                  r_op;
  logic                  w_i_req, w_d_req, w_grant_d, w_grant_i;
  always_comb begin
    w_i_req   = bus.icache_pmem_read;
    w_d_req   = bus.dcache_pmem_read | bus.dcache_pmem_write;
    w_grant_d = (r_state == IDLE) & w_d_req & (~w_i_req | ~r_last_grant);
    w_grant_i = (r_state == IDLE) & w_i_req & ~w_grant_d;
    w_next    = w_grant_d ? SERVE_D :
                w_grant_i ? SERVE_I :
                (r_state != IDLE && bus.pmem_resp) ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_op         <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grant_d) begin
        r_last_grant <= 1'b1;
        r_addr       <= bus.dcache_pmem_address;
        r_wdata      <= bus.dcache_pmem_wdata;
        r_op         <= bus.dcache_pmem_write;
      end else if (w_grant_i) begin
        r_last_grant <= 1'b0;
        r_addr       <= bus.icache_pmem_address;
      end
    end
  end
  assign bus.pmem_read         = ~reset & ((r_state == SERVE_I) | ((r_state == SERVE_D) & ~r_op));
  assign bus.pmem_write        = ~reset & (r_state == SERVE_D) & r_op;
  assign bus.pmem_address      = r_addr;
  assign bus.pmem_wdata        = r_wdata;
  assign bus.icache_pmem_rdata = bus.pmem_rdata;
  assign bus.dcache_pmem_rdata = bus.pmem_rdata;
  assign bus.icache_pmem_resp  = ~reset & (r_state == SERVE_I) & bus.pmem_resp;
  assign bus.dcache_pmem_resp  = ~reset & (r_state == SERVE_D) & bus.pmem_resp;
endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Arbitrates line-fill and write-back traffic from the I-cache and D-cache onto a single physical-memory port.
- The I-cache supplies i_mem_resp/imem_rdata to the pipeline fetch stage; the D-cache supplies dcache_rdata to the memory stage.
- Sits directly below both caches, on the path that keeps the pipeline fed.
- Serves one transaction at a time, with fair two-way arbitration and a registered grant.

Parameters:
- ADDR_WIDTH, 16, byte address width of every address port.
- LINE_WIDTH, 128, cache line width in bits for all data ports.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- icache_pmem_read  in  1  I-cache line-fill request; held until icache_pmem_resp.
- icache_pmem_address  in  ADDR_WIDTH  I-cache line address; stable while request held.
- icache_pmem_rdata  out  LINE_WIDTH  fill data to I-cache.
- icache_pmem_resp  out  1  one-cycle completion pulse to I-cache.
- dcache_pmem_read  in  1  D-cache line-fill request; held until dcache_pmem_resp.
- dcache_pmem_write  in  1  D-cache write-back request; held until dcache_pmem_resp.
- dcache_pmem_address  in  ADDR_WIDTH  D-cache line address.
- dcache_pmem_wdata  in  LINE_WIDTH  D-cache write-back data.
- dcache_pmem_rdata  out  LINE_WIDTH  fill data to D-cache.
- dcache_pmem_resp  out  1  one-cycle completion pulse to D-cache.
- pmem_read  out  1  physical memory read strobe.
- pmem_write  out  1  physical memory write strobe.
- pmem_address  out  ADDR_WIDTH  physical memory address.
- pmem_wdata  out  LINE_WIDTH  physical memory write data.
- pmem_rdata  in  LINE_WIDTH  physical memory read data.
- pmem_resp  in  1  physical memory completion; one cycle per transaction.

Behaviour:
- **States:**
  - IDLE: no grant.
  - SERVE_I: I-cache owns the port.
  - SERVE_D: D-cache owns the port.
- **Registers:**
  - state.
  - last_grant (0=I, 1=D).
  - addr_q, wdata_q, op_q (read/write), latched at grant.
- **Reset:**
  - Reset is synchronous and active-high on clk.
  - state=IDLE, last_grant=0 (so D wins the first tie), addr_q/wdata_q=0.
  - All strobes and resp outputs are 0 during and after reset.
  - Reset asserted mid-transaction aborts to IDLE. The memory-side transaction is abandoned, and a later pmem_resp is ignored.
- **IDLE arbitration** (one cycle; outputs idle while deciding):
  - D request only (read or write): go to SERVE_D, last_grant<=1.
  - I request only: go to SERVE_I, last_grant<=0.
  - Both requesting: grant the requester not granted last (round-robin).
  - Neither: stay in IDLE.
  - On grant, latch the requester's address into addr_q. For a D grant, also latch wdata into wdata_q and op into op_q.
  - dcache_pmem_read and dcache_pmem_write together is a protocol error; it is treated as a write.
- **SERVE_x:**
  - pmem_read/pmem_write are driven from state and op_q (SERVE_I is always a read).
  - pmem_address=addr_q, pmem_wdata=wdata_q.
  - Strobes are held every cycle until pmem_resp.
  - On the pmem_resp cycle, the granted cache's resp=1 for exactly that cycle, and the next state is IDLE.
- **Read data:**
  - icache_pmem_rdata and dcache_pmem_rdata are combinational copies of pmem_rdata.
  - They are valid only in the resp cycle.
- **Resp rules:**
  - The non-granted cache's resp is always 0.
  - pmem_resp arriving while in IDLE is ignored.
- **Latency:** a request in an IDLE cycle T gives strobe from T+1. With memory latency L (cycles from strobe to pmem_resp), resp arrives at T+1+L.
- **Back-to-back:** the mandatory IDLE cycle after each transaction lets the served cache drop its request before re-arbitration. The minimum gap between grants is 1 cycle.
- **Starvation:** with both caches continuously requesting, grants strictly alternate.

Test Plan:
- **Single I read:** reset, then icache_pmem_read=1 with addr 0x1230, memory resp after 3 cycles with data 0xDEAD...BEEF.
  - pmem_read=1 from the cycle after request, addr 0x1230.
  - icache_pmem_resp pulses once with that data.
  - dcache_pmem_resp stays 0.
  - Then IDLE.
- **D write-back:** dcache_pmem_write=1, addr 0x4440, wdata pattern A.
  - pmem_write=1 and pmem_read=0, pmem_address=0x4440, pmem_wdata=A, held until pmem_resp.
  - dcache_pmem_resp is a single-cycle pulse.
- **Simultaneous requests after reset:**
  - D is served first, then the IDLE cycle, then I is served.
  - Repeating the tie with both requests held alternates D, I, D, I over 4 transactions.
- **Address stability:** change icache_pmem_address mid-transaction while the I-cache is served → pmem_address keeps the latched value.
- **Reset mid-transaction:** assert reset during SERVE_D, then deliver pmem_resp the following cycle.
  - No resp is pulsed to either cache.
  - Strobes are 0.
  - state=IDLE.
  - The next tie grants D.
- **Spurious pmem_resp in IDLE:** both resp outputs stay 0 and no state change occurs.
